// File: rtl/dvp_test_source_pkg.sv
// Shared types for the DVP source selector: generator FSM states, source
// mode codes and the colour-bar level function.
package dvp_test_source_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS,
    ST_VBP,
    ST_ACT,
    ST_VFP
  } gen_state_e;

  localparam logic [1:0] MODE_CAM  = 2'd0;
  localparam logic [1:0] MODE_RAMP = 2'd1;
  localparam logic [1:0] MODE_BARS = 2'd2;
  localparam logic [1:0] MODE_FLAT = 2'd3;

  localparam int HCNT_W = 16;
  localparam int VCNT_W = 10;

  // Bar 0 is white (FF); each following bar is 32 levels darker.
  function automatic logic [7:0] bar_value(input logic [2:0] bar);
    return 8'hFF - {bar, 5'b0};
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Generated-frame DVP timing: pixel counter, line counter and frame FSM.
// Raw (unregistered) VSYNC/HREF are derived from the current state.
module dvp_timing_gen
  import dvp_test_source_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 10
) (
  input  logic       pclk_1,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic       stop_i,
  output gen_state_e state_o,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] h_cnt_o,
  output logic       line_end_o,
  output logic       frame_start_o,
  output logic       frame_end_o
);

  localparam int H_TOT = H_ACTIVE + H_BLANK;

  gen_state_e          state_q;
  logic [HCNT_W-1:0]   h_cnt_q;
  logic [VCNT_W-1:0]   v_cnt_q;
  logic [VCNT_W-1:0]   last_line;
  logic                line_end;
  logic                state_end;

  always_comb begin
    last_line = '0;
    case (state_q)
      ST_VS:   last_line = VCNT_W'(V_SYNC - 1);
      ST_VBP:  last_line = VCNT_W'(V_BP - 1);
      ST_ACT:  last_line = VCNT_W'(V_ACTIVE - 1);
      ST_VFP:  last_line = VCNT_W'(V_FP - 1);
      default: last_line = '0;
    endcase
  end

  assign line_end      = (h_cnt_q == HCNT_W'(H_TOT - 1));
  assign state_end     = line_end && (v_cnt_q == last_line);
  assign frame_end_o   = (state_q == ST_VFP) && state_end;
  // A frame starts either from IDLE on request or by wrapping out of VFP.
  assign frame_start_o = ((state_q == ST_IDLE) && start_i) || (frame_end_o && !stop_i);

  assign state_o    = state_q;
  assign vsync_o    = (state_q == ST_VS);
  assign href_o     = (state_q == ST_ACT) && (h_cnt_q < HCNT_W'(H_ACTIVE));
  assign h_cnt_o    = h_cnt_q[7:0];
  assign line_end_o = line_end;

  always_ff @(posedge pclk_1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      if (start_i) state_q <= ST_VS;
    end else begin
      if (line_end) h_cnt_q <= '0;
      else          h_cnt_q <= h_cnt_q + HCNT_W'(1);

      if (state_end) begin
        v_cnt_q <= '0;
        case (state_q)
          ST_VS:   state_q <= ST_VBP;
          ST_VBP:  state_q <= ST_ACT;
          ST_ACT:  state_q <= ST_VFP;
          ST_VFP:  state_q <= stop_i ? ST_IDLE : ST_VS;
          default: state_q <= ST_IDLE;
        endcase
      end else if (line_end) begin
        v_cnt_q <= v_cnt_q + VCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dvp_test_source.sv
// DVP source selector: forwards camera 1 or a generated test frame, switching
// only at frame boundaries. DVP_TEST_SOURCE_SCROLL_EN adds the frame count to the ramp.
module dvp_test_source
  import dvp_test_source_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 10,
  parameter int BAR_W    = H_ACTIVE / 8
) (
  input  logic       pclk_1,
  input  logic       reset_n,
  input  logic [1:0] mode_sel,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_d,
  output logic       VSYNC_o,
  output logic       HREF_o,
  output logic [7:0] D_o,
  output logic [1:0] cur_mode,
  output logic [7:0] gen_frame_cnt
);

  gen_state_e        t_state;
  logic              t_vsync;
  logic              t_href;
  logic [7:0]        t_h_cnt;
  logic              t_line_end;
  logic              t_frame_start;
  logic              t_frame_end;

  logic [1:0]        cur_mode_q, cur_mode_d;
  logic              cam_open_q, cam_open_d;
  logic              cam_vsync_q;
  logic [7:0]        gen_frame_cnt_q, gen_frame_cnt_d;
  logic [2:0]        bar_q, bar_d;
  logic [HCNT_W-1:0] bar_px_q, bar_px_d;
  logic              vsync_q, vsync_d;
  logic              href_q, href_d;
  logic [7:0]        d_q, d_d;

  logic              is_cam;
  logic              pend;
  logic              cam_rise;
  logic              start_gen;
  logic              stop_gen;
  logic [7:0]        ramp_pix;
  logic [7:0]        pix;

  dvp_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) u_timing (
    .pclk_1        (pclk_1),
    .reset_n       (reset_n),
    .start_i       (start_gen),
    .stop_i        (stop_gen),
    .state_o       (t_state),
    .vsync_o       (t_vsync),
    .href_o        (t_href),
    .h_cnt_o       (t_h_cnt),
    .line_end_o    (t_line_end),
    .frame_start_o (t_frame_start),
    .frame_end_o   (t_frame_end)
  );

  assign is_cam   = (cur_mode_q == MODE_CAM);
  assign pend     = (mode_sel != cur_mode_q);
  assign cam_rise = cam_vsync && !cam_vsync_q;

  // The camera path opens on the very VSYNC edge that is detected, so the
  // first VSYNC cycle is forwarded rather than swallowed.
  assign cam_open_d = is_cam && (cam_open_q || cam_rise);

  // Leaving the camera: immediately if it is gated, otherwise on its VSYNC rise.
  assign start_gen = is_cam && pend && (!cam_open_q || cam_rise);
  assign stop_gen  = (mode_sel == MODE_CAM);

  always_comb begin
    cur_mode_d = cur_mode_q;
    if (start_gen || (t_frame_end && pend)) cur_mode_d = mode_sel;
  end

  assign gen_frame_cnt_d = t_frame_start ? gen_frame_cnt_q + 8'd1 : gen_frame_cnt_q;

  always_comb begin
    bar_d    = bar_q;
    bar_px_d = bar_px_q;
    if (t_line_end || (t_state == ST_IDLE)) begin
      bar_d    = '0;
      bar_px_d = '0;
    end else if (t_href) begin
      if (bar_px_q == HCNT_W'(BAR_W - 1)) begin
        bar_px_d = '0;
        if (bar_q != 3'd7) bar_d = bar_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + HCNT_W'(1);
      end
    end
  end

`ifdef DVP_TEST_SOURCE_SCROLL_EN
  assign ramp_pix = t_h_cnt + gen_frame_cnt_q;
`else
  assign ramp_pix = t_h_cnt;
`endif

  always_comb begin
    pix = '0;
    case (cur_mode_q)
      MODE_RAMP: pix = ramp_pix;
      MODE_BARS: pix = bar_value(bar_q);
      MODE_FLAT: pix = gen_frame_cnt_q;
      default:   pix = '0;
    endcase
  end

  always_comb begin
    vsync_d = 1'b0;
    href_d  = 1'b0;
    d_d     = '0;
    if (is_cam) begin
      if (cam_open_d) begin
        vsync_d = cam_vsync;
        href_d  = cam_href;
        d_d     = cam_d;
      end
    end else begin
      vsync_d = t_vsync;
      href_d  = t_href;
      d_d     = t_href ? pix : 8'd0;
    end
  end

  always_ff @(posedge pclk_1 or negedge reset_n) begin
    if (!reset_n) begin
      cur_mode_q      <= MODE_CAM;
      cam_open_q      <= 1'b0;
      cam_vsync_q     <= 1'b0;
      gen_frame_cnt_q <= '0;
      bar_q           <= '0;
      bar_px_q        <= '0;
      vsync_q         <= 1'b0;
      href_q          <= 1'b0;
      d_q             <= '0;
    end else begin
      cur_mode_q      <= cur_mode_d;
      cam_open_q      <= cam_open_d;
      cam_vsync_q     <= cam_vsync;
      gen_frame_cnt_q <= gen_frame_cnt_d;
      bar_q           <= bar_d;
      bar_px_q        <= bar_px_d;
      vsync_q         <= vsync_d;
      href_q          <= href_d;
      d_q             <= d_d;
    end
  end

  assign VSYNC_o       = vsync_q;
  assign HREF_o        = href_q;
  assign D_o           = d_q;
  assign cur_mode      = cur_mode_q;
  assign gen_frame_cnt = gen_frame_cnt_q;

endmodule
